// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: carries destination tags ID->EX->MEM->WB, inserts EX bubbles and counts stalls/bubbles.
module hazard_tag_pipe #(
  parameter int CW = 16,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_rpzero,
  input  logic          stall_in,
  input  logic          flush_ex,
  output logic [RW-1:0] rd_ex,
  output logic [RW-1:0] rd_mem,
  output logic [RW-1:0] rd_wb,
  output logic          regwrite_ex,
  output logic          regwrite_mem,
  output logic          regwrite_wb,
  output logic          memread_ex,
  output logic          rpzero_ex,
  output logic          rpzero_mem,
  output logic          rpzero_wb,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          wb_we,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] bubble_cnt,
  output logic          stall_err
);
  logic w_bubble;
  assign w_bubble = stall_in | flush_ex | ~id_valid;
  assign pc_en    = ~stall_in | flush_ex;
  assign ifid_en  = pc_en;
  assign wb_we    = regwrite_wb & ~rpzero_wb;
  always_ff @(posedge clk) begin
    if (rst) begin
      {rd_ex, rd_mem, rd_wb} <= '0;
      {regwrite_ex, regwrite_mem, regwrite_wb, memread_ex} <= '0;
      {rpzero_ex, rpzero_mem, rpzero_wb} <= '1;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      stall_err  <= 1'b0;
    end else begin
      rd_wb        <= rd_mem;
      regwrite_wb  <= regwrite_mem;
      rpzero_wb    <= rpzero_mem;
      rd_mem       <= rd_ex;
      regwrite_mem <= regwrite_ex;
      rpzero_mem   <= rpzero_ex;
      rd_ex        <= w_bubble ? '0 : id_rd;
      regwrite_ex  <= ~w_bubble & id_regwrite;
      memread_ex   <= ~w_bubble & id_memread;
      rpzero_ex    <= w_bubble | id_rpzero;
      if (stall_in & ~flush_ex & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if ((stall_in | flush_ex) & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
      // a legal load-use stall needs a live load sitting in EX
      if (stall_in & ~(memread_ex & ~rpzero_ex)) stall_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb_hazard_tag_pipe: scoreboard-driven bench for hazard_tag_pipe (default CW and a CW=2 copy for saturation).
module tb_hazard_tag_pipe;
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       rz;
  } tag_t;

  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, id_rpzero = 1'b0;
  logic [4:0] id_rd = '0;
  logic stall_in = 1'b0, flush_ex = 1'b0;
  logic [4:0] rd_ex, rd_mem, rd_wb, rd_ex2, rd_mem2, rd_wb2;
  logic regwrite_ex, regwrite_mem, regwrite_wb, memread_ex, rpzero_ex, rpzero_mem, rpzero_wb;
  logic regwrite_ex2, regwrite_mem2, regwrite_wb2, memread_ex2, rpzero_ex2, rpzero_mem2, rpzero_wb2;
  logic pc_en, ifid_en, wb_we, stall_err, pc_en2, ifid_en2, wb_we2, stall_err2;
  logic [15:0] stall_cnt, bubble_cnt;
  logic [1:0] stall_cnt2, bubble_cnt2;

  int n_checks = 0, n_fail = 0;
  tag_t q[$];
  tag_t bub;
  logic [15:0] ms16, mb16;
  logic [1:0] ms2, mb2;
  logic me;

  always #5 clk = ~clk;

  hazard_tag_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_rpzero(id_rpzero), .stall_in(stall_in), .flush_ex(flush_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_ex(regwrite_ex),
    .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_ex(memread_ex),
    .rpzero_ex(rpzero_ex), .rpzero_mem(rpzero_mem), .rpzero_wb(rpzero_wb), .pc_en(pc_en),
    .ifid_en(ifid_en), .wb_we(wb_we), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .stall_err(stall_err)
  );

  hazard_tag_pipe #(.CW(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_rpzero(id_rpzero), .stall_in(stall_in), .flush_ex(flush_ex),
    .rd_ex(rd_ex2), .rd_mem(rd_mem2), .rd_wb(rd_wb2), .regwrite_ex(regwrite_ex2),
    .regwrite_mem(regwrite_mem2), .regwrite_wb(regwrite_wb2), .memread_ex(memread_ex2),
    .rpzero_ex(rpzero_ex2), .rpzero_mem(rpzero_mem2), .rpzero_wb(rpzero_wb2), .pc_en(pc_en2),
    .ifid_en(ifid_en2), .wb_we(wb_we2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2),
    .stall_err(stall_err2)
  );

  // One clock: drive ID/control, advance the model queue, then compare every stage to it.
  task automatic step(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                      input logic rz, input logic st, input logic fl, input logic r);
    tag_t e;
    id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr; id_rpzero = rz;
    stall_in = st; flush_ex = fl; rst = r;
    #1;
    n_checks++;
    if (pc_en !== (~st | fl) || ifid_en !== (~st | fl)) begin
      n_fail++; $display("FAIL enables: pc_en=%b ifid_en=%b expected %b", pc_en, ifid_en, ~st | fl);
    end
    e = (st | fl | ~v) ? bub : '{rd: rd, rw: rw, mr: mr, rz: rz};
    if (r) begin
      q = {bub, bub, bub}; ms16 = '0; mb16 = '0; ms2 = '0; mb2 = '0; me = 1'b0;
    end else begin
      if (st & ~(q[2].mr & ~q[2].rz)) me = 1'b1;
      if (st & ~fl) begin
        if (ms16 != 16'hFFFF) ms16++;
        if (ms2 != 2'd3) ms2++;
      end
      if (st | fl) begin
        if (mb16 != 16'hFFFF) mb16++;
        if (mb2 != 2'd3) mb2++;
      end
      q.push_back(e);
      void'(q.pop_front());
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rd_ex, regwrite_ex, memread_ex, rpzero_ex} !== q[2]) begin
      n_fail++; $display("FAIL ex_stage: got %h expected %h", {rd_ex, regwrite_ex, memread_ex, rpzero_ex}, q[2]);
    end
    n_checks++;
    if ({rd_mem, regwrite_mem, rpzero_mem} !== {q[1].rd, q[1].rw, q[1].rz}) begin
      n_fail++; $display("FAIL mem_stage: got %h expected %h", {rd_mem, regwrite_mem, rpzero_mem}, {q[1].rd, q[1].rw, q[1].rz});
    end
    n_checks++;
    if ({rd_wb, regwrite_wb, rpzero_wb, wb_we} !== {q[0].rd, q[0].rw, q[0].rz, q[0].rw & ~q[0].rz}) begin
      n_fail++; $display("FAIL wb_stage: got %h expected %h", {rd_wb, regwrite_wb, rpzero_wb, wb_we}, {q[0].rd, q[0].rw, q[0].rz, q[0].rw & ~q[0].rz});
    end
    n_checks++;
    if (stall_cnt !== ms16 || bubble_cnt !== mb16 || stall_err !== me) begin
      n_fail++; $display("FAIL counters: stall=%0d bubble=%0d err=%b expected %0d %0d %b", stall_cnt, bubble_cnt, stall_err, ms16, mb16, me);
    end
    n_checks++;
    if (stall_cnt2 !== ms2 || bubble_cnt2 !== mb2) begin
      n_fail++; $display("FAIL counters_cw2: stall=%0d bubble=%0d expected %0d %0d", stall_cnt2, bubble_cnt2, ms2, mb2);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(1, 5'd9, 1, 1, 0, 0, 0, 1);
    n_checks++;
    if (rd_ex !== 0 || rd_mem !== 0 || rd_wb !== 0 || {rpzero_ex, rpzero_mem, rpzero_wb} !== 3'b111 ||
        memread_ex !== 0 || wb_we !== 0 || stall_cnt !== 0 || bubble_cnt !== 0 || stall_err !== 0) begin
      n_fail++; $display("FAIL reset_state: rd=%0d/%0d/%0d rpz=%b%b%b we=%b", rd_ex, rd_mem, rd_wb, rpzero_ex, rpzero_mem, rpzero_wb, wb_we);
    end
  endtask

  task automatic test_single;
    step(1, 5'd5, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (rd_ex !== 5'd5) begin n_fail++; $display("FAIL single_ex: rd_ex=%0d expected 5", rd_ex); end
    idle(1);
    n_checks++;
    if (rd_mem !== 5'd5) begin n_fail++; $display("FAIL single_mem: rd_mem=%0d expected 5", rd_mem); end
    idle(1);
    n_checks++;
    if (rd_wb !== 5'd5 || wb_we !== 1'b1) begin n_fail++; $display("FAIL single_wb: rd_wb=%0d wb_we=%b expected 5 1", rd_wb, wb_we); end
    idle(1);
    n_checks++;
    if (rd_wb !== 0 || rpzero_wb !== 1'b1) begin n_fail++; $display("FAIL single_drain: rd_wb=%0d rpzero_wb=%b expected 0 1", rd_wb, rpzero_wb); end
  endtask

  task automatic test_load_use;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5'd8, 1, 1, 0, 0, 0, 0);
    step(1, 5'd9, 1, 0, 0, 1, 0, 0);
    n_checks++;
    if (rd_ex !== 0 || rpzero_ex !== 1'b1 || rd_mem !== 5'd8 || stall_cnt !== 16'd1 ||
        bubble_cnt !== 16'd1 || stall_err !== 1'b0) begin
      n_fail++; $display("FAIL load_use: rd_ex=%0d rpz=%b rd_mem=%0d stall=%0d bubble=%0d err=%b expected 0 1 8 1 1 0",
                         rd_ex, rpzero_ex, rd_mem, stall_cnt, bubble_cnt, stall_err);
    end
    step(1, 5'd9, 1, 0, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic test_stall_err;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5'd3, 1, 0, 0, 0, 0, 0);
    step(1, 5'd4, 1, 0, 0, 1, 0, 0);
    idle(3);
    n_checks++;
    if (stall_err !== 1'b1) begin n_fail++; $display("FAIL stall_err_sticky: stall_err=%b expected 1", stall_err); end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (stall_err !== 1'b0) begin n_fail++; $display("FAIL stall_err_reset: stall_err=%b expected 0", stall_err); end
  endtask

  task automatic test_stall_flush;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5'd8, 1, 1, 0, 0, 0, 0);
    stall_in = 1; flush_ex = 1; #1;
    n_checks++;
    if (pc_en !== 1'b1) begin n_fail++; $display("FAIL stall_flush_pc: pc_en=%b expected 1", pc_en); end
    step(1, 5'd2, 1, 0, 0, 1, 1, 0);
    n_checks++;
    if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd0 || rd_ex !== 0 || rpzero_ex !== 1'b1) begin
      n_fail++; $display("FAIL stall_flush: bubble=%0d stall=%0d rd_ex=%0d expected 1 0 0", bubble_cnt, stall_cnt, rd_ex);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5'd8, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 5'd9, 1, 0, 0, 1, 0, 0);
    n_checks++;
    if (stall_cnt2 !== 2'd3 || bubble_cnt2 !== 2'd3 || stall_cnt !== 16'd6 || stall_err !== 1'b1) begin
      n_fail++; $display("FAIL saturate: cw2 stall=%0d bubble=%0d cw16 stall=%0d err=%b expected 3 3 6 1",
                         stall_cnt2, bubble_cnt2, stall_cnt, stall_err);
    end
    idle(3);
  endtask

  task automatic test_killed_reset;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5'd7, 1, 0, 1, 0, 0, 0);
    idle(2);
    n_checks++;
    if (rd_wb !== 5'd7 || rpzero_wb !== 1'b1 || wb_we !== 1'b0) begin
      n_fail++; $display("FAIL killed_wb: rd_wb=%0d rpz=%b wb_we=%b expected 7 1 0", rd_wb, rpzero_wb, wb_we);
    end
    step(1, 5'd7, 1, 0, 1, 0, 0, 0);
    idle(1);
    step(1, 5'd6, 1, 0, 0, 0, 0, 1);
    n_checks++;
    if (rd_ex !== 0 || rd_mem !== 0 || rd_wb !== 0 || wb_we !== 1'b0 || {rpzero_ex, rpzero_mem, rpzero_wb} !== 3'b111) begin
      n_fail++; $display("FAIL midstream_reset: rd=%0d/%0d/%0d we=%b", rd_ex, rd_mem, rd_wb, wb_we);
    end
    step(1, 5'd6, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (rd_ex !== 5'd6) begin n_fail++; $display("FAIL post_reset_first: rd_ex=%0d expected 6", rd_ex); end
    idle(3);
  endtask

  initial begin
    bub = '{rd: 5'd0, rw: 1'b0, mr: 1'b0, rz: 1'b1};
    q = {bub, bub, bub};
    ms16 = '0; mb16 = '0; ms2 = '0; mb2 = '0; me = 1'b0;
    test_reset;
    test_single;
    test_load_use;
    test_stall_err;
    test_stall_flush;
    test_back_to_back;
    test_killed_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Producer side of the forwarding/stall interface. Carries each instruction's destination tag (rd, regwrite, memread, rpzero) from ID through the EX, MEM and WB stages.
- Drives the Rd_*/RegWrite_*/MemRead_EX/RPzero_* inputs of the hazard unit.
- Consumes the hazard unit's Stall plus a branch-resolution flush. Inserts bubbles into EX and gates PC / IF-ID enables.
- Keeps saturating stall/bubble performance counters and a sticky protocol-error flag.

Parameters:
CW, 16, width of stall_cnt and bubble_cnt
RW, 5, register-specifier width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
id_valid  input  1  ID stage holds a real instruction
id_rd  input  RW  destination register decoded in ID
id_regwrite  input  1  ID instruction writes the register file
id_memread  input  1  ID instruction is a load
id_rpzero  input  1  ID instruction predicated off (1 = killed)
stall_in  input  1  load-use stall from hazard unit
flush_ex  input  1  kill the instruction leaving ID (taken branch/jump)
rd_ex, rd_mem, rd_wb  output  RW each  destination tags per stage
regwrite_ex, regwrite_mem, regwrite_wb  output  1 each  write-enable tags
memread_ex  output  1  EX holds a load
rpzero_ex, rpzero_mem, rpzero_wb  output  1 each  killed flags
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID register enable
wb_we  output  1  register-file write enable = regwrite_wb & ~rpzero_wb
stall_cnt  output  CW  cycles stalled
bubble_cnt  output  CW  bubbles inserted
stall_err  output  1  sticky: stall seen without a live load in EX

Behaviour:
- All state updates on posedge clk. rst is synchronous, active-high, and has priority over every other input.
- Reset values:
  - All rd_* = 0; all regwrite_* = 0; memread_ex = 0.
  - All rpzero_* = 1, so stages read as killed.
  - stall_cnt = 0; bubble_cnt = 0; stall_err = 0.
  - wb_we = 0 (follows from the WB stage reset values).
- MEM and WB never stall:
  - Each cycle WB <= MEM and MEM <= EX, covering all tag fields.
  - memread is not carried past EX.
- EX load rule:
  - bubble = stall_in | flush_ex | ~id_valid.
  - On bubble, EX <= {rd=0, regwrite=0, memread=0, rpzero=1}.
  - Otherwise EX <= {id_rd, id_regwrite, id_memread, id_rpzero}.
- A killed instruction (id_rpzero=1) still travels with its real rd/regwrite. Consumers gate it with rpzero.
- Enables (combinational):
  - pc_en = ifid_en = ~stall_in | flush_ex.
  - flush has priority so the fetch redirect proceeds; IF/ID clearing on flush is done by the fetch logic.
- Latency: an ID tag appears on the *_ex outputs 1 cycle after capture, *_mem after 2, *_wb after 3.
- stall_cnt: +1 in each cycle with stall_in & ~flush_ex. Saturates at 2^CW-1 with no wrap.
- bubble_cnt: +1 in each cycle with stall_in | flush_ex. Bubbles caused only by ~id_valid are not counted. Saturates at 2^CW-1.
- stall_err: set in any cycle where stall_in=1 and ~(memread_ex & ~rpzero_ex). Cleared only by rst.
- Simultaneous stall_in and flush_ex: one bubble; bubble_cnt +1; stall_cnt unchanged; pc_en = 1.
- Back-to-back stall cycles:
  - Each cycle inserts a bubble.
  - The second cycle normally flags stall_err, because EX then holds a bubble; the hazard unit must never issue a 2-cycle load-use stall.
- Reset asserted mid-stream: the pipe empties in the same edge and prior tags are lost. The first post-reset ID instruction appears in EX one cycle after rst deasserts.

Test Plan:
- Reset, then id_valid=1 with id_rd=5, id_regwrite=1, id_rpzero=0 for 1 cycle -> rd_ex=5 at +1, rd_mem=5 at +2, rd_wb=5 with wb_we=1 at +3, then rd_* return to 0 and rpzero_* to 1.
- Load to r8 (memread=1) then a dependent instruction held in ID with stall_in=1 for 1 cycle -> EX shows the bubble (rd_ex=0, rpzero_ex=1), pc_en=ifid_en=0 during the stall, stall_cnt=1, bubble_cnt=1, stall_err=0; MEM shows rd_mem=8.
- stall_in=1 while EX holds a non-load (memread_ex=0) -> stall_err=1 next cycle and stays 1 until rst.
- stall_in=1 and flush_ex=1 together -> pc_en=1, bubble_cnt +1, stall_cnt unchanged, EX bubble.
- With CW=2, hold stall_in=1 (with a load in EX first) for 6 cycles -> stall_cnt saturates at 3 and bubble_cnt at 3, with no wrap.
- id_rpzero=1, id_rd=7, id_regwrite=1 -> rpzero_wb=1 and rd_wb=7 at +3, wb_we=0; assert rst at +2 -> all stages cleared at the next edge and wb_we stays 0.
